// File: rtl/updown_sweep_ctrl.sv
// ============================================================================
// Module   : updown_sweep_ctrl
// Brief    : Command-driven up/down/ping-pong sweep sequencer for an N-bit
//            counter. It accepts bounds, a mode and a sweep count over a
//            valid/ready handshake, then steps Count through the pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_sweep_ctrl #(
  parameter int WIDTH = 5,
  parameter int LOOPW = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [1:0]       cmd_mode,
  input  logic [LOOPW-1:0] cmd_loops,
  input  logic             abort,
  output logic [WIDTH-1:0] Count,
  output logic             UpOrDown,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN_UP   = 2'd1,
    S_RUN_DOWN = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] c_mode_down = 2'b01;
  localparam logic [1:0] c_mode_pp   = 2'b10;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [LOOPW-1:0] r_loops, w_loops_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             r_err, w_err_nxt;
  logic             w_sweep_end;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_mode  <= '0;
      r_loops <= '0;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_mode  <= w_mode_nxt;
      r_loops <= w_loops_nxt;
      r_dir   <= w_dir_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and datapath update; abort outranks the end-of-sweep decision.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_mode_nxt  = r_mode;
    w_loops_nxt = r_loops;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_sweep_end = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_lo_nxt    = cmd_lo;
          w_hi_nxt    = cmd_hi;
          w_mode_nxt  = cmd_mode;
          w_loops_nxt = cmd_loops;
          if (cmd_lo > cmd_hi) begin
            w_err_nxt = 1'b1;
          end else if (cmd_mode == c_mode_down) begin
            w_count_nxt = cmd_hi;
            w_dir_nxt   = 1'b0;
            w_state_nxt = S_RUN_DOWN;
          end else begin
            // Up, ping-pong and the reserved encoding all start upward.
            w_count_nxt = cmd_lo;
            w_dir_nxt   = 1'b1;
            w_state_nxt = S_RUN_UP;
          end
        end
      end
      S_RUN_UP: begin
        if (abort) begin
          w_state_nxt = S_DONE;
        end else if (r_count < r_hi) begin
          w_count_nxt = r_count + 1'b1;
        end else if (r_mode == c_mode_pp && r_lo != r_hi) begin
          // Turn at hi without repeating it.
          w_count_nxt = r_hi - 1'b1;
          w_dir_nxt   = 1'b0;
          w_state_nxt = S_RUN_DOWN;
        end else begin
          w_sweep_end = 1'b1;
        end
      end
      S_RUN_DOWN: begin
        if (abort) begin
          w_state_nxt = S_DONE;
        end else if (r_count > r_lo) begin
          w_count_nxt = r_count - 1'b1;
        end else begin
          w_sweep_end = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_sweep_end) begin
      w_loops_nxt = (r_loops != '0) ? r_loops - 1'b1 : '0;
      if (r_loops == LOOPW'(1)) begin
        w_state_nxt = S_DONE;
      end else begin
        w_wrap_nxt = 1'b1;
        if (r_mode == c_mode_down) begin
          w_count_nxt = r_hi;
          w_state_nxt = S_RUN_DOWN;
        end else if (r_mode == c_mode_pp) begin
          // lo was just visited on the way down, so restart one above it.
          w_count_nxt = (r_lo == r_hi) ? r_lo : r_lo + 1'b1;
          w_dir_nxt   = 1'b1;
          w_state_nxt = S_RUN_UP;
        end else begin
          w_count_nxt = r_lo;
          w_state_nxt = S_RUN_UP;
        end
      end
    end
  end

  assign Count     = r_count;
  assign UpOrDown  = r_dir;
  assign busy      = (r_state == S_RUN_UP) || (r_state == S_RUN_DOWN);
  assign cmd_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign wrap      = r_wrap;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
// ============================================================================
// Module   : tb_updown_sweep_ctrl
// Brief    : Self-checking bench for updown_sweep_ctrl. Expected sequences are
//            generated per sweep from the bounds, mode and loop count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_sweep_ctrl;

  localparam int WIDTH = 5;
  localparam int LOOPW = 4;

  logic             Clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_lo;
  logic [WIDTH-1:0] cmd_hi;
  logic [1:0]       cmd_mode;
  logic [LOOPW-1:0] cmd_loops;
  logic             abort;
  logic [WIDTH-1:0] Count;
  logic             UpOrDown;
  logic             busy;
  logic             wrap;
  logic             done;
  logic             err;

  int errors = 0;
  int checks = 0;

  int exp_c[$];
  int exp_d[$];
  int exp_w[$];

  updown_sweep_ctrl #(.WIDTH(WIDTH), .LOOPW(LOOPW)) dut (
    .Clk(Clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_mode(cmd_mode),
    .cmd_loops(cmd_loops), .abort(abort), .Count(Count),
    .UpOrDown(UpOrDown), .busy(busy), .wrap(wrap), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  // Builds the expected Count/direction/wrap sequence sweep by sweep.
  task automatic build_model(input int lo, input int hi, input int mode,
                             input int loops, input int limit);
    int s;
    s = 0;
    exp_c.delete(); exp_d.delete(); exp_w.delete();
    while ((loops == 0) ? (exp_c.size() < limit) : (s < loops)) begin
      int first;
      first = exp_c.size();
      if (lo == hi) begin
        exp_c.push_back(lo); exp_d.push_back((mode == 1) ? 0 : 1); exp_w.push_back(0);
      end else if (mode == 1) begin
        for (int v = hi; v >= lo; v--) begin
          exp_c.push_back(v); exp_d.push_back(0); exp_w.push_back(0);
        end
      end else if (mode == 2) begin
        for (int v = (s == 0) ? lo : lo + 1; v <= hi; v++) begin
          exp_c.push_back(v); exp_d.push_back(1); exp_w.push_back(0);
        end
        for (int v = hi - 1; v >= lo; v--) begin
          exp_c.push_back(v); exp_d.push_back(0); exp_w.push_back(0);
        end
      end else begin
        for (int v = lo; v <= hi; v++) begin
          exp_c.push_back(v); exp_d.push_back(1); exp_w.push_back(0);
        end
      end
      if (s > 0) exp_w[first] = 1;
      s++;
    end
  endtask

  // Issues one valid command from IDLE and follows it through DONE back to IDLE.
  task automatic run_cmd(input int lo, input int hi, input int mode, input int loops,
                         input int abort_at, input bit hold);
    int n;
    int ab;
    ab = abort_at;
    if (loops == 0 && ab < 0) ab = 12;
    build_model(lo, hi, mode, loops, ab + 1);
    n = (ab >= 0 && ab < exp_c.size()) ? ab + 1 : exp_c.size();
    cmd_lo = WIDTH'(lo); cmd_hi = WIDTH'(hi);
    cmd_mode = 2'(mode); cmd_loops = LOOPW'(loops);
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before_cmd: got %b want 1", cmd_ready);
    end
    @(posedge Clk); #1;
    if (!hold) cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (Count !== WIDTH'(exp_c[i]) || UpOrDown !== exp_d[i][0] || wrap !== exp_w[i][0] ||
          busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL seq[%0d] lo=%0d hi=%0d mode=%0d: got Count=%0d dir=%b wrap=%b busy=%b rdy=%b done=%b want Count=%0d dir=%0d wrap=%0d busy=1 rdy=0 done=0",
                 i, lo, hi, mode, Count, UpOrDown, wrap, busy, cmd_ready, done,
                 exp_c[i], exp_d[i], exp_w[i]);
      end
      if (i == ab) abort = 1'b1;
      @(posedge Clk); #1;
      abort = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0 || wrap !== 1'b0 ||
        Count !== WIDTH'(exp_c[n-1]) || UpOrDown !== exp_d[n-1][0]) begin
      errors++;
      $display("FAIL done_state: got done=%b busy=%b rdy=%b wrap=%b Count=%0d dir=%b want 1 0 0 0 %0d %0d",
               done, busy, cmd_ready, wrap, Count, UpOrDown, exp_c[n-1], exp_d[n-1]);
    end
    @(posedge Clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || Count !== WIDTH'(exp_c[n-1])) begin
      errors++;
      $display("FAIL idle_after_done: got done=%b busy=%b rdy=%b Count=%0d want 0 0 1 %0d",
               done, busy, cmd_ready, Count, exp_c[n-1]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (Count !== '0 || UpOrDown !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        wrap !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got Count=%0d dir=%b busy=%b rdy=%b wrap=%b done=%b err=%b want 0 0 0 1 0 0 0",
               Count, UpOrDown, busy, cmd_ready, wrap, done, err);
    end
  endtask

  task automatic test_directed();
    run_cmd(0, 31, 0, 1, -1, 1'b0);
    run_cmd(3, 6, 1, 2, -1, 1'b0);
    run_cmd(2, 4, 2, 2, -1, 1'b0);
    run_cmd(7, 7, 0, 3, -1, 1'b0);
    run_cmd(7, 7, 2, 2, -1, 1'b0);
    run_cmd(0, 31, 2, 1, -1, 1'b0);
    run_cmd(0, 1, 2, 3, -1, 1'b0);
  endtask

  task automatic test_abort_hold();
    // Count 5,6,7 -> abort raised while Count=7; cmd_valid held throughout.
    run_cmd(5, 9, 0, 0, 2, 1'b1);
    @(posedge Clk); #1;
    checks++;
    if (busy !== 1'b1 || Count !== WIDTH'(5) || UpOrDown !== 1'b1) begin
      errors++;
      $display("FAIL held_cmd_accept: got busy=%b Count=%0d dir=%b want 1 5 1", busy, Count, UpOrDown);
    end
    cmd_valid = 1'b0;
    abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || Count !== WIDTH'(5)) begin
      errors++;
      $display("FAIL abort_immediate: got done=%b Count=%0d want 1 5", done, Count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_error();
    logic [WIDTH-1:0] c0;
    c0 = Count;
    cmd_lo = 5'd10; cmd_hi = 5'd4; cmd_mode = 2'd0; cmd_loops = 4'd1;
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || Count !== c0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b busy=%b rdy=%b Count=%0d want 1 0 1 %0d",
               err, busy, cmd_ready, Count, c0);
    end
    @(posedge Clk); #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || Count !== c0) begin
      errors++;
      $display("FAIL err_clear: got err=%b busy=%b Count=%0d want 0 0 %0d", err, busy, Count, c0);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    cmd_lo = 5'd0; cmd_hi = 5'd31; cmd_mode = 2'd2; cmd_loops = 4'd0;
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    while (Count !== 5'd20 && guard < 40) begin
      @(posedge Clk); #1;
      guard++;
    end
    checks++;
    if (Count !== 5'd20) begin
      errors++;
      $display("FAIL reach_20: got Count=%0d want 20", Count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (Count !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 || UpOrDown !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got Count=%0d busy=%b rdy=%b dir=%b want 0 0 1 0",
               Count, busy, cmd_ready, UpOrDown);
    end
    @(negedge Clk); reset = 1'b0;
    @(posedge Clk); #1;
    run_cmd(1, 3, 2, 1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int lo, hi, mode, loops, ab;
      lo = $urandom_range(0, 31);
      hi = $urandom_range(0, 31);
      mode = $urandom_range(0, 3);
      loops = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0 || loops == 0) ? $urandom_range(0, 40) : -1;
      if (lo > hi && $urandom_range(0, 2) != 0) begin
        int t;
        t = lo; lo = hi; hi = t;
      end
      if (lo > hi) test_error();
      else run_cmd(lo, hi, mode, loops, ab, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_lo = '0; cmd_hi = '0; cmd_mode = '0; cmd_loops = '0;
    #1;
    test_reset();
    @(negedge Clk); reset = 1'b0;
    @(posedge Clk); #1;
    test_reset();
    test_directed();
    test_abort_hold();
    test_error();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Command-driven sequencer for an N-bit up/down counter datapath. It accepts a sweep command over a valid/ready handshake: bounds lo/hi, mode (up, down, ping-pong) and sweep count. It then steps an internal Count register through the programmed pattern, driving the UpOrDown direction and reporting wrap, done and error events. It sits between a control/CPU-side requester and any logic consuming Count.

Parameters:
WIDTH, 5, bit width of Count, cmd_lo, cmd_hi
LOOPW, 4, bit width of cmd_loops (sweep counter)

Ports:
Clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_lo  input  WIDTH  lower bound, inclusive
cmd_hi  input  WIDTH  upper bound, inclusive
cmd_mode  input  2  00 up, 01 down, 10 ping-pong, 11 reserved (treated as up)
cmd_loops  input  LOOPW  number of sweeps; 0 = run until abort
abort  input  1  terminate the running sequence
Count  output  WIDTH  current counter value
UpOrDown  output  1  current direction: 1 up, 0 down
busy  output  1  sequence in progress
wrap  output  1  one-cycle pulse on the first cycle of each sweep after the first
done  output  1  one-cycle pulse when the sequence ends
err  output  1  one-cycle pulse on a rejected command

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high, port name reset.
- Reset values, applied immediately, including mid-sequence: state IDLE, Count=0, UpOrDown=0, busy=0, cmd_ready=1, wrap=0, done=0, err=0, sweep counter=0.
- States: IDLE, RUN_UP, RUN_DOWN, DONE.
- IDLE:
  - cmd_ready=1. A handshake is cmd_valid & cmd_ready at a rising edge; all cmd_* fields are latched at that edge.
  - If lo > hi, the command is consumed and rejected: err=1 for the next cycle, state stays IDLE, Count unchanged.
  - Otherwise, at the handshake edge: busy=1, cmd_ready=0.
  - Up and ping-pong: Count=lo, UpOrDown=1, go to RUN_UP.
  - Down: Count=hi, UpOrDown=0, go to RUN_DOWN.
  - The start value is visible in the cycle after the handshake edge.
- RUN_UP:
  - Count < hi: Count+1 per edge.
  - Count == hi, up mode: sweep ends.
  - Count == hi, ping-pong: go to RUN_DOWN with UpOrDown=0 and Count=hi-1 at the same edge. If lo == hi, the sweep ends instead.
- RUN_DOWN:
  - Count > lo: Count-1 per edge.
  - Count == lo: sweep ends (down and ping-pong modes).
- Sweep end:
  - Decrement the sweep counter, saturating at 0.
  - If the sweep counter was 1, go to DONE; Count holds.
  - Otherwise (more sweeps remain, or loops=0) start the next sweep at the same edge: wrap=1 for that cycle.
  - Up: Count=lo. Down: Count=hi. Ping-pong: Count=lo+1, UpOrDown=1, state RUN_UP (lo itself is not repeated). If lo == hi, Count=lo.
- Ping-pong turning points appear exactly once per turn. Example lo=2, hi=4: 2,3,4,3,2,3,4,3,2.
- lo == hi: each sweep lasts one cycle at Count=lo, in every mode.
- Full range (lo=0, hi=2^WIDTH-1): no arithmetic overflow; Count never leaves [lo, hi].
- abort: sampled only in RUN_UP and RUN_DOWN. At that edge go to DONE with Count frozen at its current value. abort takes priority over sweep end and wrap. abort in IDLE or DONE is ignored.
- DONE: lasts one cycle with done=1 and busy=0, then IDLE. cmd_ready is 0 in DONE and returns to 1 in IDLE.
- Count and UpOrDown hold their last values in IDLE until the next accepted command.
- cmd_valid while busy is not accepted; the source holds its command.

Test Plan:
- Up, lo=0, hi=31, loops=1 -> Count 0..31 on consecutive cycles with UpOrDown=1; done=1 the cycle after Count=31, Count holds 31; then cmd_ready=1.
- Down, lo=3, hi=6, loops=2 -> 6,5,4,3,6,5,4,3 with wrap=1 only on the second 6; done follows, Count=3, UpOrDown=0 throughout.
- Ping-pong, lo=2, hi=4, loops=2 -> 2,3,4,3,2,3,4,3,2; UpOrDown 1,1,1,0,0,1,1,0,0; wrap=1 on the second-sweep 3; one done pulse.
- Up, lo=5, hi=9, loops=0, abort while Count=7 -> Count frozen at 7; done next cycle; busy=0; no further counting; cmd_valid held during the run is not accepted until IDLE.
- lo=10, hi=4 -> err pulse, no busy, Count unchanged. lo=hi=7, loops=3, up -> Count=7 for 3 cycles with wrap on cycles 2 and 3, then done.
- Ping-pong 0..31 running, assert reset at Count=20 (asynchronous, mid-cycle) -> Count=0, busy=0, cmd_ready=1 immediately; a new command is accepted after reset deasserts.
